// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle bridge between the core's memory port and the
// data-memory bus. Builds one aligned word transaction per load/store, stalls
// the core while it is in flight and returns the loaded word right-justified.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} LsuState;

  localparam int CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  LsuState          lsuState_q, lsuState_d;
  logic [CntW-1:0]  timeoutCnt_q;
  logic [1:0]       offset_q;
  logic [31:0]      busAddr_q, busWdata_q, readData_q;
  logic [3:0]       busBe_q;
  logic             busWe_q, busError_q;

  logic             accessAligned, accept, inFlight, timeoutHit, respDone;
  logic [3:0]       beNext;
  logic [31:0]      wdataNext;
  logic             unusedFunct3;

  // The sign/unsigned bit of funct3 belongs to the load-extension stage.
  assign unusedFunct3 = mem_funct3[2];

  assign inFlight   = (lsuState_q == REQ) || (lsuState_q == WAIT);
  assign accept     = (lsuState_q == IDLE) && mem_req && accessAligned;
  assign respDone   = (lsuState_q == WAIT) && bus_rvalid;
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && inFlight &&
                      (32'(timeoutCnt_q) == 32'(TIMEOUT_CYCLES - 1));

  // Size-dependent alignment check; the 11 encoding never counts as aligned.
  always_comb begin
    accessAligned = 1'b0;
    case (mem_funct3[1:0])
      2'b00:   accessAligned = 1'b1;
      2'b01:   accessAligned = ~address[0];
      2'b10:   accessAligned = (address[1:0] == 2'b00);
      default: accessAligned = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated write data for the access about to start.
  always_comb begin
    beNext    = 4'b1111;
    wdataNext = write_data;
    case (mem_funct3[1:0])
      2'b00: begin
        beNext    = 4'b0001 << address[1:0];
        wdataNext = {4{write_data[7:0]}};
      end
      2'b01: begin
        beNext    = 4'b0011 << address[1:0];
        wdataNext = {2{write_data[15:0]}};
      end
      default: begin
        beNext    = 4'b1111;
        wdataNext = write_data;
      end
    endcase
  end

  // State register; reset drops straight back to IDLE, killing any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lsuState_q <= IDLE;
    else       lsuState_q <= lsuState_d;
  end

  // Next-state logic; a timeout in REQ wins over a same-cycle grant, while in
  // WAIT a response arriving with the timeout wins.
  always_comb begin
    lsuState_d = lsuState_q;
    case (lsuState_q)
      IDLE: if (accept) lsuState_d = REQ;
      REQ: begin
        if (timeoutHit)   lsuState_d = DONE;
        else if (bus_gnt) lsuState_d = WAIT;
      end
      WAIT: begin
        if (bus_rvalid)      lsuState_d = DONE;
        else if (timeoutHit) lsuState_d = DONE;
      end
      default: lsuState_d = IDLE;
    endcase
  end

  // Core-facing and bus-request outputs decoded from the current state.
  always_comb begin
    bus_req    = (lsuState_q == REQ);
    stall      = accept || inFlight;
    misaligned = (lsuState_q == IDLE) && mem_req && !accessAligned;
  end

  // Transaction registers, timeout counter, load result and fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busAddr_q    <= 32'h0;
      busWdata_q   <= 32'h0;
      busBe_q      <= 4'b0000;
      busWe_q      <= 1'b0;
      offset_q     <= 2'b00;
      readData_q   <= 32'h0;
      busError_q   <= 1'b0;
      timeoutCnt_q <= '0;
    end else begin
      if (accept) begin
        busAddr_q  <= {address[31:2], 2'b00};
        busWe_q    <= mem_we;
        busBe_q    <= beNext;
        busWdata_q <= wdataNext;
        offset_q   <= address[1:0];
      end
      if (accept)        timeoutCnt_q <= '0;
      else if (inFlight) timeoutCnt_q <= timeoutCnt_q + 1'b1;
      if (respDone) begin
        if (bus_err)       readData_q <= 32'h0;
        else if (!busWe_q) readData_q <= bus_rdata >> {offset_q, 3'b000};
      end else if (timeoutHit) begin
        readData_q <= 32'h0;
      end
      busError_q <= respDone ? bus_err : timeoutHit;
    end
  end

  assign bus_addr  = busAddr_q;
  assign bus_we    = busWe_q;
  assign bus_be    = busBe_q;
  assign bus_wdata = busWdata_q;
  assign read_data = readData_q;
  assign bus_error = busError_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized accesses checked against a
// behavioural model of the load/store unit's bus and core-side behaviour.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] address, write_data;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  logic [31:0] read_data, bus_addr, bus_wdata;
  logic        stall, misaligned, bus_error, bus_req, bus_we;
  logic [3:0]  bus_be;

  logic [31:0] t_read_data, t_bus_addr, t_bus_wdata;
  logic        t_stall, t_misaligned, t_bus_error, t_bus_req, t_bus_we;
  logic [3:0]  t_bus_be;

  int          assertCount = 0;
  int          failCount = 0;
  logic [31:0] modelRead = 32'h0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_funct3(mem_funct3), .address(address), .write_data(write_data),
    .read_data(read_data), .stall(stall), .misaligned(misaligned),
    .bus_error(bus_error), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dutTimeout (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_funct3(mem_funct3), .address(address), .write_data(write_data),
    .read_data(t_read_data), .stall(t_stall), .misaligned(t_misaligned),
    .bus_error(t_bus_error), .bus_req(t_bus_req), .bus_we(t_bus_we),
    .bus_addr(t_bus_addr), .bus_be(t_bus_be), .bus_wdata(t_bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic bit modelAligned(input logic [31:0] addr, input logic [1:0] sz);
    if (sz == 2'b11) return 1'b0;
    return (addr % (32'd1 << sz)) == 32'd0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [1:0] off, input logic [1:0] sz);
    logic [3:0] be;
    int n;
    be = 4'b0000;
    n  = 1 << sz;
    for (int k = 0; k < n; k++) begin
      if (int'(off) + k < 4) be[int'(off) + k] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] r;
    int n;
    r = 32'h0;
    n = 1 << sz;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % n) +: 8];
    return r;
  endfunction

  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] f3,
                               input logic we, input logic [31:0] wd,
                               input logic [31:0] rd, input int gntDelay,
                               input int rvDelay, input logic err);
    bit          ok;
    logic [31:0] expAddr, expWd;
    logic [3:0]  expBe;
    ok      = modelAligned(addr, f3[1:0]);
    expAddr = {addr[31:2], 2'b00};
    expBe   = modelBe(addr[1:0], f3[1:0]);
    expWd   = modelWdata(wd, f3[1:0]);

    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_funct3 = f3; address = addr; write_data = wd;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    #1;
    checkOutput("accept.stall", stall, ok);
    checkOutput("accept.misaligned", misaligned, !ok);
    checkOutput("accept.bus_req", bus_req, 0);
    if (!ok) begin
      @(negedge clk);
      mem_req = 1'b0;
      #1;
      checkOutput("misal.bus_req", bus_req, 0);
      checkOutput("misal.stall", stall, 0);
      checkOutput("misal.pulse_end", misaligned, 0);
      checkOutput("misal.read_data", read_data, modelRead);
      return;
    end

    for (int i = 0; i <= gntDelay; i++) begin
      @(negedge clk);
      bus_gnt = (i == gntDelay);
      bus_rdata = $urandom;
      #1;
      checkOutput("req.bus_req", bus_req, 1);
      checkOutput("req.stall", stall, 1);
      checkOutput("req.bus_addr", bus_addr, expAddr);
      checkOutput("req.bus_be", bus_be, expBe);
      checkOutput("req.bus_we", bus_we, we);
      checkOutput("req.bus_wdata", bus_wdata, expWd);
    end

    for (int j = 0; j <= rvDelay; j++) begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = (j == rvDelay);
      bus_err    = (j == rvDelay) ? err : 1'($urandom_range(0, 1));
      bus_rdata  = (j == rvDelay) ? rd : $urandom;
      #1;
      checkOutput("wait.bus_req", bus_req, 0);
      checkOutput("wait.stall", stall, 1);
    end
    if (err)      modelRead = 32'h0;
    else if (!we) modelRead = rd >> (8 * addr[1:0]);

    @(negedge clk);
    bus_rvalid = 1'($urandom_range(0, 1));
    bus_err    = 1'($urandom_range(0, 1));
    bus_rdata  = $urandom;
    #1;
    checkOutput("done.stall", stall, 0);
    checkOutput("done.bus_req", bus_req, 0);
    checkOutput("done.bus_error", bus_error, err);
    checkOutput("done.read_data", read_data, modelRead);

    @(negedge clk);
    mem_req    = 1'b0;
    bus_gnt    = 1'($urandom_range(0, 1));
    bus_rvalid = 1'($urandom_range(0, 1));
    #1;
    checkOutput("idle.stall", stall, 0);
    checkOutput("idle.bus_req", bus_req, 0);
    checkOutput("idle.bus_error", bus_error, 0);
    checkOutput("idle.read_data", read_data, modelRead);
  endtask

  // Directed steps, randomized accesses, timeout and reset scenarios.
  initial begin
    reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_funct3 = 3'b000;
    address = 32'h0; write_data = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    bus_err = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.read_data", read_data, 0);
    checkOutput("reset.stall", stall, 0);
    checkOutput("reset.bus_req", bus_req, 0);
    checkOutput("reset.bus_we", bus_we, 0);
    checkOutput("reset.bus_addr", bus_addr, 0);
    checkOutput("reset.bus_be", bus_be, 0);
    checkOutput("reset.bus_wdata", bus_wdata, 0);
    checkOutput("reset.misaligned", misaligned, 0);
    checkOutput("reset.bus_error", bus_error, 0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(32'h8000_0010, 3'b010, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    applyStimulus(32'h8000_0013, 3'b000, 1'b0, 32'h0, 32'hAABB_CCDD, 0, 0, 1'b0);
    applyStimulus(32'h8000_0006, 3'b001, 1'b1, 32'h1234_5678, 32'h0, 1, 2, 1'b0);
    applyStimulus(32'h8000_0002, 3'b010, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0);
    applyStimulus(32'h8000_0001, 3'b001, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0);
    applyStimulus(32'h8000_0000, 3'b011, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0);
    applyStimulus(32'h8000_0020, 3'b010, 1'b0, 32'h0, 32'h1111_2222, 10, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom, {1'b0, 2'($urandom_range(0, 3))}, 1'($urandom_range(0, 1)),
                    $urandom, $urandom, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    reset = 1'b1; mem_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    modelRead = 32'h0;
    applyStimulus(32'h0000_0100, 3'b010, 1'b0, 32'h0, 32'h1234_5678, 0, 0, 1'b0);
    checkOutput("tmo.prior_load", t_read_data, 32'h1234_5678);

    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_funct3 = 3'b010; address = 32'h0000_0200;
    write_data = 32'hA5A5_A5A5; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    #1;
    checkOutput("tmo.accept.stall", t_stall, 1);
    checkOutput("tmo.accept.misaligned", t_misaligned, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checkOutput("tmo.req.bus_req", t_bus_req, 1);
      checkOutput("tmo.req.bus_addr", t_bus_addr, 32'h0000_0200);
      checkOutput("tmo.req.bus_be", t_bus_be, 4'b1111);
      checkOutput("tmo.req.bus_we", t_bus_we, 0);
      checkOutput("tmo.req.bus_wdata", t_bus_wdata, 32'hA5A5_A5A5);
    end
    @(negedge clk);
    #1;
    checkOutput("tmo.done.bus_req", t_bus_req, 0);
    checkOutput("tmo.done.bus_error", t_bus_error, 1);
    checkOutput("tmo.done.stall", t_stall, 0);
    checkOutput("tmo.done.read_data", t_read_data, 0);
    @(negedge clk);
    mem_req = 1'b0;
    #1;
    checkOutput("tmo.idle.bus_error", t_bus_error, 0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelRead = 32'h0;
    applyStimulus(32'h0000_0300, 3'b010, 1'b0, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_funct3 = 3'b010; address = 32'h0000_0304;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    @(negedge clk);
    bus_gnt = 1'b1;
    #1;
    checkOutput("rst.req.bus_req", bus_req, 1);
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    checkOutput("rst.wait.stall", stall, 1);
    #2;
    reset = 1'b1; mem_req = 1'b0;
    #1;
    modelRead = 32'h0;
    checkOutput("rst.async.stall", stall, 0);
    checkOutput("rst.async.bus_req", bus_req, 0);
    checkOutput("rst.async.read_data", read_data, 0);
    checkOutput("rst.async.bus_addr", bus_addr, 0);
    checkOutput("rst.async.bus_be", bus_be, 0);
    @(negedge clk);
    reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
    #1;
    checkOutput("rst.stale.stall", stall, 0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    checkOutput("rst.stale.read_data", read_data, 0);
    checkOutput("rst.stale.bus_error", bus_error, 0);
    checkOutput("rst.stale.bus_req", bus_req, 0);
    applyStimulus(32'h0000_0042, 3'b001, 1'b0, 32'h0, 32'h9876_5432, 2, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
